// File: rtl/niu32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : niu32_pkg
//  Description : Shared Niu32 definitions: word size, memory-mapped I/O
//                register addresses and the MMIO responder state encoding.
//                Imported by the CPU side and by the I/O responder.
//  Revision    : 1.0  initial release
// ============================================================================
package niu32_pkg;

  localparam int WORD_SIZE = 32;

  // I/O register map (all word aligned, full 32-bit decode)
  localparam logic [31:0] ADDR_HEX     = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hFFFF_0020;
  localparam logic [31:0] ADDR_LEDG    = 32'hFFFF_0040;
  localparam logic [31:0] ADDR_KEY     = 32'hFFFF_0100;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hFFFF_0104;
  localparam logic [31:0] ADDR_SWITCH  = 32'hFFFF_0120;

  // Four-phase handshake sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_WAIT   = 2'd3
  } mmio_state_e;

endpackage
`default_nettype wire

// File: rtl/SevenSeg.sv
`default_nettype none
// ============================================================================
//  Module      : SevenSeg
//  Description : Hex digit to seven-segment pattern, active-low segments,
//                bit order {g,f,e,d,c,b,a}.
//  Ports       : hex [3:0] in  - digit value
//                seg [6:0] out - segment drive (0 = lit)
//  Revision    : 1.0  initial release
// ============================================================================
module SevenSeg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/niu32_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : niu32_key_debounce
//  Description : One board key: 2-flop synchroniser, inversion to
//                active-high, stability counter and a press pulse on the
//                cycle the debounced level goes released -> pressed.
//  Ports       : clk, reset_n         - clock, async active-low reset
//                key_n_in    in       - raw key, active-low, asynchronous
//                pressed     out      - debounced level, 1 = pressed
//                press_pulse out      - 1 for the edge that accepts a press
//  Revision    : 1.0  initial release
// ============================================================================
module niu32_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_in,
  output logic pressed,
  output logic press_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             synced;

  always_comb begin
    meta_d      = key_n_in;
    sync_d      = meta_q;
    synced      = ~sync_q;
    stable_d    = stable_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d    = synced;
      cnt_d       = '0;
      press_pulse = synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser flops come out of reset at the raw "released" level (high)
  // so a key that is up during reset never looks pressed for two cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed = stable_q;

endmodule
`default_nettype wire

// File: rtl/niu32_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : niu32_mmio_responder
//  Description : Niu32 memory-mapped I/O target. Serves CPU loads/stores to
//                0xFFFF0000-0xFFFF01FF and owns HEX display, LEDs, debounced
//                keys with sticky press flags and synchronised switches.
//  Ports       : clk, reset_n            - clock, async active-low reset
//                req/wr/addr/wdata  in   - CPU request (held until ack)
//                rdata/ack/err      out  - response, ack is a 1-cycle pulse
//                key_in [3:0]       in   - raw keys, active-low
//                sw_in  [9:0]       in   - raw switches
//                ledr/ledg          out  - LED registers
//                hex0..hex3         out  - seven-segment digits of HEX reg
//  Revision    : 1.0  initial release
// ============================================================================
module niu32_mmio_responder
  import niu32_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 wr,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ack,
  output logic                 err,
  input  logic [3:0]           key_in,
  input  logic [9:0]           sw_in,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3
);

  mmio_state_e          state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [15:0]          hex_reg_q, hex_reg_d;
  logic [9:0]           ledr_q, ledr_d;
  logic [7:0]           ledg_q, ledg_d;
  logic [3:0]           keyedge_q, keyedge_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [9:0]           sw_meta_q, sw_meta_d;
  logic [9:0]           sw_sync_q, sw_sync_d;

  logic [3:0]           key_level;
  logic [3:0]           key_rise;
  logic [3:0]           keyedge_clr;
  logic [6:0]           seg [4];
  logic                 hit_hex, hit_ledr, hit_ledg, hit_key, hit_keyedge, hit_sw;
  logic                 acc_err;
  logic [WORD_SIZE-1:0] rd_val;
  logic                 unused_wdata_hi;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_key
      niu32_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n_in    (key_in[i]),
        .pressed     (key_level[i]),
        .press_pulse (key_rise[i])
      );
    end
    for (genvar i = 0; i < 4; i++) begin : g_hex
      SevenSeg u_seg (
        .hex (hex_reg_q[4*i +: 4]),
        .seg (seg[i])
      );
    end
  endgenerate

  // Decode works from the latched request so the CPU may drop req early.
  always_comb begin
    hit_hex     = (addr_q == ADDR_HEX);
    hit_ledr    = (addr_q == ADDR_LEDR);
    hit_ledg    = (addr_q == ADDR_LEDG);
    hit_key     = (addr_q == ADDR_KEY);
    hit_keyedge = (addr_q == ADDR_KEYEDGE);
    hit_sw      = (addr_q == ADDR_SWITCH);
    acc_err     = ~(hit_hex | hit_ledr | hit_ledg | hit_key | hit_keyedge | hit_sw)
                | (addr_q[1:0] != 2'b00)
                | (wr_q & (hit_key | hit_sw));
    rd_val = '0;
    if (hit_hex)          rd_val = {16'h0, hex_reg_q};
    else if (hit_ledr)    rd_val = {22'h0, ledr_q};
    else if (hit_ledg)    rd_val = {24'h0, ledg_q};
    else if (hit_key)     rd_val = {28'h0, key_level};
    else if (hit_keyedge) rd_val = {28'h0, keyedge_q};
    else if (hit_sw)      rd_val = {22'h0, sw_sync_q};
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    hex_reg_d   = hex_reg_q;
    ledr_d      = ledr_q;
    ledg_d      = ledg_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    keyedge_clr = 4'h0;
    sw_meta_d   = sw_in;
    sw_sync_d   = sw_meta_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wr_d    = wr;
          wdata_d = wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = '0;
        if (!acc_err) begin
          if (wr_q) begin
            if (hit_hex)     hex_reg_d   = wdata_q[15:0];
            if (hit_ledr)    ledr_d      = wdata_q[9:0];
            if (hit_ledg)    ledg_d      = wdata_q[7:0];
            if (hit_keyedge) keyedge_clr = wdata_q[3:0];
          end else begin
            rdata_d = rd_val;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        err_d   = acc_err;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A press landing in the same cycle as a clear keeps its flag.
    keyedge_d = (keyedge_q & ~keyedge_clr) | key_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      hex_reg_q <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      keyedge_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      hex_reg_q <= hex_reg_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      keyedge_q <= keyedge_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // Only the low 16 store-data bits feed any register.
  assign unused_wdata_hi = ^wdata_q[31:16];

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign ledr  = ledr_q;
  assign ledg  = ledg_q;
  assign hex0  = seg[0];
  assign hex1  = seg[1];
  assign hex2  = seg[2];
  assign hex3  = seg[3];

endmodule
`default_nettype wire
